divu_sequencer: RTL and testbench
=================================

Name: divu_sequencer

Overview:
- Control stage directly upstream of the unsigned pipelined divider core, and owner of the architectural HI/LO registers.
- Accepts DIV/DIVU requests from the execute stage and screens divide-by-zero.
- Converts signed operands to magnitudes, issues one request to the core, waits for its result, applies sign fixup, and writes LO=quotient, HI=remainder.
- Also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

Parameters:
- TIMEOUT_CYCLES, 40, maximum WAIT cycles allowed for div_ready before the operation is abandoned.
- CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a division; sampled only in IDLE
- op_signed  in  1  1=DIV (two's complement), 0=DIVU
- op_a  in  32  dividend
- op_b  in  32  divisor
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in flight; execute stage stalls
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  sticky; last operation had op_b==0
- timeout  out  1  sticky; last operation got no div_ready
- div_valid  out  1  one-cycle issue strobe to core
- div_dividend  out  32  unsigned dividend magnitude to core
- div_divisor  out  32  unsigned divisor magnitude to core
- div_ready  in  1  core result valid
- div_quotient  in  32  core unsigned quotient
- div_remainder  in  32  core unsigned remainder
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: clock is clock; reset is synchronous, active-high.
- Reset values: state=IDLE; hi=lo=0; busy=done=div_valid=0; div_by_zero=timeout=0; div_dividend=div_divisor=0; counter=0.
- Reset mid-operation: aborts immediately, HI/LO are not written, and any later div_ready is ignored.
- States: IDLE, ISSUE, WAIT, FIXUP, DONE.
- IDLE, start=1:
  - Clears div_by_zero and timeout.
  - If op_b==0: set div_by_zero=1, go to DONE; HI/LO unchanged; div_valid never asserted.
  - Otherwise latch magnitudes:
    - Signed: |op_a|, |op_b|, where |0x80000000| = 0x80000000 treated as unsigned.
    - Unsigned: raw values.
  - Latch neg_q = op_signed & (op_a[31]^op_b[31]) and neg_r = op_signed & op_a[31]; go to ISSUE.
- ISSUE: div_valid=1 for exactly this cycle; clear counter; go to WAIT. div_dividend/div_divisor stay stable from ISSUE until DONE.
- WAIT:
  - div_ready=1: capture quotient/remainder, go to FIXUP.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES, set timeout=1 and go to DONE with HI/LO unchanged.
- FIXUP: lo <= neg_q ? 0-q : q; hi <= neg_r ? 0-r : r (32-bit wrap); go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- busy=1 in ISSUE, WAIT, FIXUP; busy=0 in IDLE and DONE.
- Latency: start at cycle 0 → div_valid at cycle 1. With div_ready at cycle k, HI/LO update at the edge ending k+1 and done=1 in cycle k+2.
- Divide-by-zero latency: done=1 in cycle 1.
- start outside IDLE: ignored, not queued.
- div_ready outside WAIT: ignored.
- MTHI/MTLO:
  - Honoured only when busy=0; the register updates at the next edge.
  - mthi and mtlo together write both registers.
  - In IDLE, an MT write coinciding with start is performed; the division's FIXUP write later overrides it.
  - While busy, MT writes are dropped.
- Overflow 0x80000000 / -1 (signed): magnitudes 0x80000000 and 1; result lo=0x80000000, hi=0; no flag.

Test Plan:
- Unsigned 100/7, bench core answers ready 3 cycles after div_valid → div_dividend=100, div_divisor=7, lo=14, hi=2, single done pulse, busy low in the done cycle.
- Signed -7/2 (0xFFFFFFF9 / 2) → core sees 7/2, returns q=3 r=1 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed 7/-2 → lo=0xFFFFFFFD, hi=1.
- Signed -8/-3 → lo=2, hi=0xFFFFFFFE.
- Divide by zero:
  - Stimulus: preload mthi=0xAAAA and mtlo=0x5555, then start with op_b=0.
  - Response: done in cycle 1, div_by_zero=1, div_valid never high, hi=0xAAAA, lo=0x5555.
  - Then a valid 9/3 clears the flag and gives lo=3, hi=0.
- Signed 0x80000000 / 0xFFFFFFFF → div_dividend=0x80000000, div_divisor=1, lo=0x80000000, hi=0.
- Robustness:
  - Core never asserts div_ready → timeout=1 after 40 WAIT cycles, HI/LO unchanged.
  - Reset asserted in WAIT, then div_ready pulses → state IDLE, hi=lo=0, no done.
  - start pulsed while busy → ignored.

Source files
------------

// File: rtl/divu_sequencer.sv
// DIV/DIVU control stage: screens divide-by-zero, issues magnitudes to the
// unsigned divider core, applies sign fixup and owns the HI/LO registers.
module divu_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        timeout,
  output logic        div_valid,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_ready,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [2:0]  fsm_state
);

  // Core handshake: div_valid is a single-cycle issue strobe; the core answers
  // with a single div_ready cycle carrying quotient/remainder, honoured in WAIT only.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r;
  logic [31:0]       q_reg, r_reg;
  logic [31:0]       a_mag, b_mag;
  logic              b_zero;

  assign fsm_state = state;
  assign b_zero    = (op_b == 32'd0);
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_mag     = (op_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign b_mag     = (op_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    div_valid  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = b_zero ? DONE : ISSUE;
      ISSUE: begin
        busy       = 1'b1;
        div_valid  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (div_ready)             state_next = FIXUP;
        else if (cnt == CNT_LIMIT) state_next = DONE;
      end
      FIXUP: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      q_reg        <= 32'd0;
      r_reg        <= 32'd0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      div_by_zero  <= 1'b0;
      timeout      <= 1'b0;
      hi           <= 32'd0;
      lo           <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div_by_zero <= b_zero;
          timeout     <= 1'b0;
          if (!b_zero) begin
            div_dividend <= a_mag;
            div_divisor  <= b_mag;
            neg_q        <= op_signed & (op_a[31] ^ op_b[31]);
            neg_r        <= op_signed & op_a[31];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (div_ready) begin
            q_reg <= div_quotient;
            r_reg <= div_remainder;
          end else if (cnt == CNT_LIMIT) begin
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIXUP: begin
          lo <= neg_q ? (32'd0 - q_reg) : q_reg;
          hi <= neg_r ? (32'd0 - r_reg) : r_reg;
        end
        default: ;
      endcase
      // FIXUP is a busy state, so MT writes never collide with the result write.
      if (!busy) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_divu_sequencer.sv
// Randomised and directed bench for divu_sequencer with a behavioural divider
// core and an arithmetic reference model for HI/LO.
module tb_divu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, op_signed, mthi, mtlo, div_ready;
  logic [31:0] op_a, op_b, wdata, div_quotient, div_remainder;
  logic        busy, done, div_by_zero, timeout, div_valid;
  logic [31:0] div_dividend, div_divisor, hi, lo;
  logic [2:0]  fsm_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic [31:0] exp_q[$];

  divu_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .timeout(timeout),
    .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .hi(hi), .lo(lo), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of DIV/DIVU using wide signed arithmetic.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic [31:0] ma, output logic [31:0] mb);
    longint sa, sb, q64, r64, aa, ab;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q64 = sa / sb;
      r64 = sa % sb;
      aa = (sa < 0) ? -sa : sa;
      ab = (sb < 0) ? -sb : sb;
      q = q64[31:0];
      r = r64[31:0];
      ma = aa[31:0];
      mb = ab[31:0];
    end else begin
      q = a / b;
      r = a % b;
      ma = a;
      mb = b;
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    mthi = h; mtlo = l; wdata = d;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
  endtask

  // Runs one division; delay = WAIT cycles before the core answers.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int delay, input logic poke);
    logic [31:0] q, r, ma, mb, gl, gh;
    int n;
    start = 1'b1; op_a = a; op_b = b; op_signed = sgn;
    step();
    start = 1'b0;
    if (b == 32'd0) begin
      check("dbz_done", {31'd0, done}, 32'd1);
      check("dbz_valid", {31'd0, div_valid}, 32'd0);
      check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
      step();
      check("dbz_hi", hi, exp_hi);
      check("dbz_lo", lo, exp_lo);
      return;
    end
    ref_div(a, b, sgn, q, r, ma, mb);
    exp_q.push_back(q);
    exp_q.push_back(r);
    check("issue_valid", {31'd0, div_valid}, 32'd1);
    check("issue_busy", {31'd0, busy}, 32'd1);
    check("issue_dividend", div_dividend, ma);
    check("issue_divisor", div_divisor, mb);
    step();
    check("valid_one_cycle", {31'd0, div_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin
        start = 1'b1; op_a = $urandom; op_b = 32'd0; op_signed = ~sgn;
      end
      step();
      start = 1'b0;
    end
    div_ready = 1'b1;
    div_quotient  = (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
    div_remainder = (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
    step();
    div_ready = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("result_latency", n, 1);
    gl = exp_q.pop_front();
    gh = exp_q.pop_front();
    exp_lo = gl;
    exp_hi = gh;
    check("done_busy", {31'd0, busy}, 32'd0);
    check("res_lo", lo, exp_lo);
    check("res_hi", hi, exp_hi);
    check("res_dbz", {31'd0, div_by_zero}, 32'd0);
    check("res_timeout", {31'd0, timeout}, 32'd0);
    step();
    check("done_single", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; op_signed = 1'b0; op_a = 0; op_b = 0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 0;
    div_ready = 1'b0; div_quotient = 0; div_remainder = 0;
    repeat (3) step();
    check("rst_state", {29'd0, fsm_state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valid", {31'd0, div_valid}, 32'd0);
    check("rst_flags", {30'd0, div_by_zero, timeout}, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    step();

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, 3, 1'b0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 2, 1'b0);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1, 1'b0);
    do_div(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 0, 1'b0);
    mt_write(1'b1, 1'b0, 32'h0000_AAAA);
    mt_write(1'b0, 1'b1, 32'h0000_5555);
    do_div(32'd123, 32'd0, 1'b1, 0, 1'b0);
    do_div(32'd9, 32'd3, 1'b0, 2, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    do_div(32'd1000, 32'd33, 1'b0, 4, 1'b1);
    mt_write(1'b1, 1'b1, 32'h1234_5678);

    // Timeout: core never answers; an MT write while busy is dropped.
    start = 1'b1; op_a = 32'd55; op_b = 32'd5; op_signed = 1'b0;
    step();
    start = 1'b0;
    step();
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    check("to_done_seen", {31'd0, done}, 32'd1);
    check("to_not_early", {31'd0, n >= 38}, 32'd1);
    check("to_flag", {31'd0, timeout}, 32'd1);
    check("to_hi", hi, exp_hi);
    check("to_lo", lo, exp_lo);
    step();

    // Reset during WAIT, then a stale div_ready
    start = 1'b1; op_a = 32'd50; op_b = 32'd5; op_signed = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    div_ready = 1'b1; div_quotient = 32'd10; div_remainder = 32'd0;
    step();
    div_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) n++;
      step();
    end
    check("rstmid_no_done", n, 0);
    check("rstmid_state", {29'd0, fsm_state}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;

    // Randomised operations interleaved with MT writes
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 20);
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        mt_write($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      do_div(a, b, $urandom_range(0, 1) == 1, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
